// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, state and single-cycle datapath definitions for alu_pipe
package alu_pkg;

   localparam int OP_W  = 4;
   localparam int MAX_W = 32;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_NOT = 4'd4,
      OP_XOR = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_MUL = 4'd8
   } alu_op_e;

   typedef logic [1:0] alu_state_t;
   localparam alu_state_t ST_IDLE = 2'd0;
   localparam alu_state_t ST_MUL  = 2'd1;
   localparam alu_state_t ST_DONE = 2'd2;

   typedef struct packed {
      logic [MAX_W-1:0] result;
      logic             carry;
      logic             ovf;
      logic             illegal;
   } alu_res_t;

   // Operands arrive zero-extended to MAX_W; width selects the live LSBs.
   // MUL is not a single-cycle op, so it is reported illegal here and the
   // caller decides whether the sequential multiplier takes it instead.
   function automatic alu_res_t alu_comb(input logic [OP_W-1:0]  op,
                                         input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input int unsigned      width);
      alu_res_t         r;
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] am;
      logic [MAX_W-1:0] bm;
      logic [MAX_W:0]   wide;
      logic [5:0]       cbit;
      logic [4:0]       sbit;
      logic             sa;
      logic             sb;
      logic             sr;
      mask = 32'((33'd1 << width) - 33'd1);
      am   = a & mask;
      bm   = b & mask;
      cbit = 6'(width);
      sbit = 5'(width - 1);
      sa   = am[sbit];
      sb   = bm[sbit];
      r    = '0;
      wide = '0;
      case (op)
         OP_ADD: begin
            wide     = {1'b0, am} + {1'b0, bm};
            r.result = wide[MAX_W-1:0] & mask;
            r.carry  = wide[cbit];
            sr       = r.result[sbit];
            r.ovf    = (sa == sb) && (sr != sa);
         end
         OP_SUB: begin
            wide     = {1'b0, am} - {1'b0, bm};
            r.result = wide[MAX_W-1:0] & mask;
            r.carry  = (am < bm);
            sr       = r.result[sbit];
            r.ovf    = (sa != sb) && (sr != sa);
         end
         OP_AND: r.result = am & bm;
         OP_OR:  r.result = am | bm;
         OP_NOT: r.result = ~am & mask;
         OP_XOR: r.result = am ^ bm;
         OP_SHL: r.result = (bm >= width) ? '0 : ((am << bm[4:0]) & mask);
         OP_SHR: r.result = (bm >= width) ? '0 : (am >> bm[4:0]);
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add unsigned multiplier, one partial product per cycle
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, busy_d;
   logic [2*WIDTH-1:0] step_sum;

   // Accumulator after this cycle's step; on the last step it is the full product.
   always_comb begin
      step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   assign done    = busy_q && (count_q == LAST);
   assign product = step_sum;

   // Load operands on start, otherwise shift multiplicand left and multiplier right.
   always_comb begin
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         count_d  = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = step_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + 1'b1;
         if (count_q == LAST) begin
            busy_d = 1'b0;
         end
      end
   end

   // Multiplier state; reset abandons any product in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with flags and a multi-cycle multiplier
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_illegal
);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             illegal_q, illegal_d;

   logic [MAX_W-1:0]   a_ext;
   logic [MAX_W-1:0]   b_ext;
   alu_res_t           comb_res;
   logic               unused_comb_bits;
   logic               accept;
   logic               is_mul;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign out_valid = (state_q == ST_DONE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (in_op == OP_MUL) && MUL_EN;
   assign mul_start = accept && is_mul;

   // Single-cycle datapath on the zero-extended operands.
   always_comb begin
      a_ext            = '0;
      b_ext            = '0;
      a_ext[WIDTH-1:0] = in_a;
      b_ext[WIDTH-1:0] = in_b;
      comb_res         = alu_comb(in_op, a_ext, b_ext, 32'(WIDTH));
      unused_comb_bits = ^comb_res.result;
   end

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mul_start),
      .a      (in_a),
      .b      (in_b),
      .done   (mul_done),
      .product(mul_product)
   );

   // Next state and next output register; outputs only change when a result loads.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      neg_d     = neg_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;
      if (accept) begin
         if (is_mul) begin
            state_d = ST_MUL;
         end else begin
            state_d   = ST_DONE;
            result_d  = comb_res.result[WIDTH-1:0];
            zero_d    = (comb_res.result[WIDTH-1:0] == '0);
            neg_d     = comb_res.result[WIDTH-1];
            carry_d   = comb_res.carry;
            ovf_d     = comb_res.ovf;
            illegal_d = comb_res.illegal;
         end
      end else if (state_q == ST_MUL) begin
         if (mul_done) begin
            state_d   = ST_DONE;
            result_d  = mul_product[WIDTH-1:0];
            zero_d    = (mul_product[WIDTH-1:0] == '0);
            neg_d     = mul_product[WIDTH-1];
            carry_d   = |mul_product[2*WIDTH-1:WIDTH];
            ovf_d     = 1'b0;
            illegal_d = 1'b0;
         end
      end else if (state_q == ST_DONE) begin
         if (out_ready) begin
            state_d = ST_IDLE;
         end
      end else if (state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end
   end

   // FSM state and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         neg_q     <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         neg_q     <= neg_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
      end
   end

   assign out_result  = result_q;
   assign out_zero    = zero_q;
   assign out_neg     = neg_q;
   assign out_carry   = carry_q;
   assign out_ovf     = ovf_q;
   assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with directed vectors
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready;
   logic [3:0] in_op;
   logic [7:0] in_a, in_b;
   logic       out_valid, out_ready;
   logic [7:0] out_result;
   logic       out_zero, out_neg, out_carry, out_ovf, out_illegal;

   logic       n_in_valid, n_in_ready;
   logic [3:0] n_in_op;
   logic [7:0] n_in_a, n_in_b;
   logic       n_out_valid, n_out_ready;
   logic [7:0] n_out_result;
   logic       n_out_zero, n_out_neg, n_out_carry, n_out_ovf, n_out_illegal;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [7:0] res;
      logic [4:0] flags;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
      .out_ovf(out_ovf), .out_illegal(out_illegal)
   );

   alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .rst_n(rst_n),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .in_op(n_in_op), .in_a(n_in_a), .in_b(n_in_b),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .out_result(n_out_result),
      .out_zero(n_out_zero), .out_neg(n_out_neg), .out_carry(n_out_carry),
      .out_ovf(n_out_ovf), .out_illegal(n_out_illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+2; holds the request until accepted, then queues the expectation.
   task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [4:0] flags,
                        input int lat, input bit push);
      exp_t e;
      int   waited = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      #4;
      while (in_ready !== 1'b1 && waited < 50) begin
         @(posedge clk);
         #6;
         waited++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: in_ready=%b, expected 1 within 50 cycles", name, in_ready);
         @(posedge clk);
         #2;
         in_valid = 1'b0;
         return;
      end
      if (push) begin
         e.name  = name;
         e.res   = res;
         e.flags = flags;
         e.lat   = lat;
         e.acc   = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #2;
      check({name, "_drain"}, sb.size(), 0);
   endtask

   // Monitor: compares the presented result against the queue head every valid cycle.
   initial begin
      bit seen = 0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: out_valid=1 result=0x%0h, expected no pending result",
                        out_result);
            end else begin
               if (!seen) begin
                  seen = 1;
                  check({sb[0].name, "_latency"}, cyc - sb[0].acc + 1, sb[0].lat);
               end
               check({sb[0].name, "_result"}, {out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal},
                     {sb[0].res, sb[0].flags});
               if (out_ready === 1'b1) begin
                  void'(sb.pop_front());
                  seen = 0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   // Flags below are packed as {zero, neg, carry, ovf, illegal}.
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
      n_in_valid = 1'b0; n_in_op = '0; n_in_a = '0; n_in_b = '0; n_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_outputs", {out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      issue("add_ff_01", 4'h0, 8'hFF, 8'h01, 8'h00, 5'b10100, 1, 1);
      issue("add_7f_01", 4'h0, 8'h7F, 8'h01, 8'h80, 5'b01010, 1, 1);
      issue("sub_03_05", 4'h1, 8'h03, 8'h05, 8'hFE, 5'b01100, 1, 1);
      issue("mul_13_11", 4'h8, 8'h13, 8'h11, 8'h43, 5'b00100, 9, 1);
      check("mul_in_ready_start", in_ready, 0);
      check("mul_out_valid_start", out_valid, 0);
      repeat (4) @(posedge clk);
      #2;
      check("mul_in_ready_mid", in_ready, 0);
      drain("first");

      out_ready = 1'b0;
      issue("xor_f0_3c", 4'h5, 8'hF0, 8'h3C, 8'hCC, 5'b01000, 1, 1);
      for (int i = 0; i < 5; i++) begin
         #4;
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      issue("and_f0_3c", 4'h2, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1, 1);

      issue("shl_81_3", 4'h6, 8'h81, 8'h03, 8'h08, 5'b00000, 1, 1);
      issue("shl_01_7", 4'h6, 8'h01, 8'h07, 8'h80, 5'b01000, 1, 1);
      issue("shr_81_8", 4'h7, 8'h81, 8'h08, 8'h00, 5'b10000, 1, 1);
      issue("shr_80_7", 4'h7, 8'h80, 8'h07, 8'h01, 5'b00000, 1, 1);
      issue("illegal_a", 4'hA, 8'h12, 8'h34, 8'h00, 5'b10001, 1, 1);
      issue("illegal_f", 4'hF, 8'hFF, 8'hFF, 8'h00, 5'b10001, 1, 1);
      issue("or_0f_30", 4'h3, 8'h0F, 8'h30, 8'h3F, 5'b00000, 1, 1);
      issue("not_55", 4'h4, 8'h55, 8'h00, 8'hAA, 5'b01000, 1, 1);
      issue("sub_80_01", 4'h1, 8'h80, 8'h01, 8'h7F, 5'b00010, 1, 1);
      issue("add_01_02", 4'h0, 8'h01, 8'h02, 8'h03, 5'b00000, 1, 1);
      issue("mul_0f_0f", 4'h8, 8'h0F, 8'h0F, 8'hE1, 5'b01000, 9, 1);
      drain("second");

      issue("mul_abort", 4'h8, 8'h13, 8'h11, 8'h00, 5'b00000, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_outputs", {out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal}, 0);
      check("abort_in_ready", in_ready, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #4;
      check("abort_in_ready_after", in_ready, 1);
      repeat (15) @(posedge clk);
      #2;
      check("abort_no_stale", out_valid, 0);

      n_in_valid = 1'b1; n_in_op = 4'h8; n_in_a = 8'h13; n_in_b = 8'h11;
      #4;
      check("nomul_in_ready", n_in_ready, 1);
      check("nomul_pre_valid", n_out_valid, 0);
      @(posedge clk);
      #2;
      n_in_valid = 1'b0;
      #4;
      check("nomul_out_valid", n_out_valid, 1);
      check("nomul_result", {n_out_result, n_out_zero, n_out_neg, n_out_carry, n_out_ovf, n_out_illegal},
            {8'h00, 5'b10001});
      @(posedge clk);
      #2;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
